sram_arbiter: RTL

- Shares the single base SRAM controller (sram_ctrl) between two masters.
  - Master 0: CPU path from devctrl.
  - Master 1: a burst-less DMA / framebuffer fetch port.
- Each master presents a held request; the arbiter grants one, registers its command, drives sram_ctrl until completion, and returns a one-cycle ack with read data.
- Sits between devctrl/DMA and sram_ctrl in thinpad_top.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arbiter_rr.sv | 25 ++
 rtl/sram_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-master SRAM arbiter: FSM encoding,
// master index constants and the timeout-counter width helper.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Counter wide enough to hold the value TIMEOUT itself.
    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Combinational 2-way picker. With both requests active it either favours
// master 0 (fixed priority) or the master that was not granted last.
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       grant,
    output logic       valid
);

    // Pick a winner from the current request vector.
    always_comb begin
        valid = |req;
        grant = M0;
        unique case (req)
            2'b01:   grant = M0;
            2'b10:   grant = M1;
            2'b11:   grant = fixed_prio ? M0 : ~last_grant;
            default: grant = M0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one sram_ctrl between the CPU path (master 0) and a DMA/framebuffer
// port (master 1). A granted command is registered, held on the controller
// pins while in ISSUE, and answered with a one-cycle ack (plus err on
// timeout) to the granted master. Handshake: a master holds req with a
// stable command until it sees ack, then drops or replaces req in that same
// cycle; reqs are not looked at during ACK, so every transaction is
// followed by at least one IDLE cycle.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [3:0]        m0_be_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [3:0]        m1_be_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              enable_o,
    output logic              readEnable_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        byteSelect_o,
    output logic [DATA_W-1:0] dataSave_o,
    input  logic [DATA_W-1:0] dataLoad_i,
    input  logic              busy_i
);

    localparam int              TMO_W    = tmo_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic            FP       = (FIXED_PRIO != 0);

    arb_state_t        state_q, state_d;
    logic              last_grant_q;
    logic              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              abort_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              pick;
    logic              pick_valid;
    logic              take;
    logic              done;
    logic              tmo_hit;

    rr_arbiter2 u_pick (
        .req        ({m1_req_i, m0_req_i}),
        .last_grant (last_grant_q),
        .fixed_prio (FP),
        .grant      (pick),
        .valid      (pick_valid)
    );

    // Event decode: grant in IDLE, completion or abort in ISSUE.
    always_comb begin
        take    = (state_q == IDLE) && pick_valid;
        done    = (state_q == ISSUE) && !busy_i;
        tmo_hit = (state_q == ISSUE) && busy_i && (tmo_q == TMO_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   if (done || tmo_hit) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset parks in IDLE so enable_o drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Latch the winning command and remember who won for round-robin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= M1;
            gnt_q        <= M0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else if (take) begin
            last_grant_q <= pick;
            gnt_q        <= pick;
            if (pick == M1) begin
                we_q    <= m1_we_i;
                addr_q  <= m1_addr_i;
                be_q    <= m1_be_i;
                wdata_q <= m1_wdata_i;
            end else begin
                we_q    <= m0_we_i;
                addr_q  <= m0_addr_i;
                be_q    <= m0_be_i;
                wdata_q <= m0_wdata_i;
            end
        end
    end

    // Count busy cycles in ISSUE; cleared whenever a new command may start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                tmo_q <= '0;
        else if (state_q != ISSUE)              tmo_q <= '0;
        else if (busy_i && !tmo_hit)            tmo_q <= tmo_q + 1'b1;
    end

    // Remember whether the transaction finished by timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          abort_q <= 1'b0;
        else if (tmo_hit) abort_q <= 1'b1;
        else if (done)    abort_q <= 1'b0;
    end

    // Per-master read data: loaded on read completion, zeroed on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (tmo_hit) begin
            if (gnt_q == M1) rdata1_q <= '0;
            else             rdata0_q <= '0;
        end else if (done && !we_q) begin
            if (gnt_q == M1) rdata1_q <= dataLoad_i;
            else             rdata0_q <= dataLoad_i;
        end
    end

    // Controller pins and master responses.
    always_comb begin
        enable_o     = (state_q == ISSUE);
        readEnable_o = (state_q == ISSUE) && !we_q;
        addr_o       = addr_q;
        byteSelect_o = be_q;
        dataSave_o   = wdata_q;
        m0_ack_o     = (state_q == ACK) && (gnt_q == M0);
        m1_ack_o     = (state_q == ACK) && (gnt_q == M1);
        m0_err_o     = m0_ack_o && abort_q;
        m1_err_o     = m1_ack_o && abort_q;
        m0_rdata_o   = rdata0_q;
        m1_rdata_o   = rdata1_q;
    end

endmodule
